// File: rtl/dcache_dm_wt.sv
// dcache_dm_wt: direct-mapped, write-through, no-write-allocate L1 data cache
// with one 32-bit word per line. It sits between the load/store unit and a
// backing data memory.
//
// Parameters:
//   ADDR_WIDTH - byte address width
//   LINES      - number of lines (power of two, >= 2)
//   IDX_W      - derived index width
//   TAG_W      - derived tag width
//
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   req_valid/req_ready         - request handshake
//   req_we, req_addr,
//   req_funct3, req_wdata       - request fields (RV32 funct3, right-aligned data)
//   inv                         - invalidate all lines (only acted on in IDLE)
//   resp_valid, resp_rdata,
//   resp_err                    - one-cycle response pulse
//   mem_req/mem_ack             - backing memory handshake
//   mem_we, mem_addr, mem_wdata,
//   mem_wstrb, mem_rdata        - backing memory transfer fields
//
// Optional feature (macro DCACHE_STATS_EN): adds saturating 32-bit hit_cnt and
// miss_cnt outputs that count accepted legal load hits and misses.
module dcache_dm_wt #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINES = 64,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_wdata,
  input  logic                  inv,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MEM_RD = 2'd1;
  localparam logic [1:0] MEM_WR = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [31:0]           wdata_q;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic [1:0]       req_off;
  logic [IDX_W-1:0] req_idx, idx_q;
  logic [TAG_W-1:0] req_tag, tagr_q;
  logic             req_hit, req_err, accept, wr_hit;
  logic [3:0]       strb;

  // Selects the byte/half at the given offset and extends it per funct3.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'd0, h};
      3'b010:  extract = w;
      default: extract = 32'd0;
    endcase
  endfunction

  // Illegal funct3 for the access direction, or a misaligned half/word.
  function automatic logic check_err(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic illegal, mis;
    if (we) illegal = f3[2] | (f3[1:0] == 2'b11);
    else    illegal = (f3[1:0] == 2'b11) | (f3 == 3'b110);
    mis = ((f3[1:0] == 2'b01) & off[0]) | ((f3[1:0] == 2'b10) & (off != 2'b00));
    check_err = illegal | mis;
  endfunction

  assign req_off = req_addr[1:0];
  assign req_idx = req_addr[IDX_W+1:2];
  assign req_tag = req_addr[ADDR_WIDTH-1:IDX_W+2];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign req_err = check_err(req_we, req_funct3, req_off);

  assign req_ready = rst_n && (state_q == IDLE) && !inv;
  assign accept    = req_valid && req_ready;

  assign idx_q  = addr_q[IDX_W+1:2];
  assign tagr_q = addr_q[ADDR_WIDTH-1:IDX_W+2];
  // Hit status for a store is evaluated at the ack; the array cannot change
  // between acceptance and ack, so this equals the lookup-time result.
  assign wr_hit = valid_q[idx_q] && (tag_q[idx_q] == tagr_q);

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   strb = 4'b0001 << addr_q[1:0];
      2'b01:   strb = 4'b0011 << addr_q[1:0];
      default: strb = 4'b1111;
    endcase
  end

  assign mem_req    = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign mem_we     = (state_q == MEM_WR);
  assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata  = wdata_q << {addr_q[1:0], 3'b000};
  assign mem_wstrb  = (state_q == MEM_WR) ? strb : 4'b0000;

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? resp_rdata_q : 32'd0;
  assign resp_err   = resp_valid ? resp_err_q : 1'b0;

  always_comb begin
    state_d      = state_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
          if (req_err) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (req_we) begin
            state_d = MEM_WR;
          end else if (req_hit) begin
            state_d      = RESP;
            resp_rdata_d = extract(data_q[req_idx], req_off, req_funct3);
          end else begin
            state_d = MEM_RD;
          end
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          state_d      = RESP;
          resp_rdata_d = extract(mem_rdata, addr_q[1:0], funct3_q);
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          state_d      = RESP;
          resp_rdata_d = 32'd0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      if (state_q == IDLE && inv) valid_q <= '0;
      else if (state_q == MEM_RD && mem_ack) valid_q[idx_q] <= 1'b1;
    end
  end

  // Request capture and tag/data arrays carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= req_addr;
      we_q     <= req_we;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
    end
    if (rst_n && state_q == MEM_RD && mem_ack) begin
      tag_q[idx_q]  <= tagr_q;
      data_q[idx_q] <= mem_rdata;
    end
    if (rst_n && state_q == MEM_WR && mem_ack && wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) data_q[idx_q][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else if (accept && !req_err && !req_we) begin
      if (req_hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_dcache_dm_wt.sv
// tb_dcache_dm_wt: self-checking bench for dcache_dm_wt (default build,
// LINES=64). A table of directed load/store vectors with hand-computed results
// is applied in a loop against a simple backing memory model, followed by
// hand-written sequences for invalidate-vs-request and reset during a miss.
module tb_dcache_dm_wt;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        inv;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dcache_dm_wt #(.ADDR_WIDTH(32), .LINES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .inv(inv),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Backing memory: 256 words, acks one cycle after it first sees mem_req.
  logic [31:0] memArr [256];
  logic        memEnable;
  int          waitCnt;
  logic        memSeen;
  logic [31:0] seenAddr, seenWdata;
  logic        seenWe;
  logic [3:0]  seenStrb;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      memSeen   = 1'b1;
      seenAddr  = mem_addr;
      seenWe    = mem_we;
      seenWdata = mem_wdata;
      seenStrb  = mem_wstrb;
    end
    if (mem_req && memEnable) begin
      if (waitCnt == 1) begin
        mem_ack   = 1'b1;
        mem_rdata = memArr[mem_addr[9:2]];
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) memArr[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
        waitCnt = 0;
      end else begin
        waitCnt = waitCnt + 1;
      end
    end else begin
      waitCnt = 0;
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] expRdata;
    logic        expErr;
    logic        expMem;
    int          expLat;
    logic [31:0] expMemAddr;
    logic [3:0]  expStrb;
    logic [31:0] expMemWdata;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string name, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input logic [31:0] expRdata, input logic expErr,
                        input logic expMem, input int expLat,
                        input logic [31:0] expMemAddr, input logic [3:0] expStrb,
                        input logic [31:0] expMemWdata);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.f3 = f3; v.wd = wd;
    v.expRdata = expRdata; v.expErr = expErr; v.expMem = expMem; v.expLat = expLat;
    v.expMemAddr = expMemAddr; v.expStrb = expStrb; v.expMemWdata = expMemWdata;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request from a negedge and waits for its response; lat counts
  // negedges after the acceptance edge up to the one showing resp_valid.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [2:0] f3, input logic [31:0] wd,
                               output logic [31:0] rdata, output logic err,
                               output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    memSeen    = 1'b0;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat   = 0;
    rdata = 32'hDEAD_DEAD;
    err   = 1'b1;
    while (lat <= 40) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic [31:0] rdata;
  logic        err;
  int          lat;
  int          strayResp;

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = 32'h0101_0101 * i;
    memArr[64]  = 32'h8765_4321;
    memArr[128] = 32'h2222_2222;
    memArr[209] = 32'h0000_0000;
    memArr[254] = 32'h5A5A_1234;
    memEnable = 1'b1;
    waitCnt = 0;
    memSeen = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_funct3 = 3'd0;
    req_wdata = 32'd0; inv = 1'b0;

    //      name            we  addr        f3      wdata         rdata        err  mem lat memaddr      strb     memwdata
    addVec("lw miss",       0, 32'h100, 3'b010, 32'h0,        32'h87654321, 0, 1, 3, 32'h100, 4'b0000, 32'h0);
    addVec("lw hit",        0, 32'h100, 3'b010, 32'h0,        32'h87654321, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("lb 103",        0, 32'h103, 3'b000, 32'h0,        32'hFFFFFF87, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("lbu 103",       0, 32'h103, 3'b100, 32'h0,        32'h00000087, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("lh 102",        0, 32'h102, 3'b001, 32'h0,        32'hFFFF8765, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("lhu 100",       0, 32'h100, 3'b101, 32'h0,        32'h00004321, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("sb 101 hit",    1, 32'h101, 3'b000, 32'h123456AB, 32'h0,        0, 1, 3, 32'h100, 4'b0010, 32'h3456AB00);
    addVec("lw after sb",   0, 32'h100, 3'b010, 32'h0,        32'h8765AB21, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("sw 344 miss",   1, 32'h344, 3'b010, 32'hCAFEF00D, 32'h0,        0, 1, 3, 32'h344, 4'b1111, 32'hCAFEF00D);
    addVec("lw 344 noalloc",0, 32'h344, 3'b010, 32'h0,        32'hCAFEF00D, 0, 1, 3, 32'h344, 4'b0000, 32'h0);
    addVec("lh 101 misal",  0, 32'h101, 3'b001, 32'h0,        32'h0,        1, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("ld f3 011",     0, 32'h100, 3'b011, 32'h0,        32'h0,        1, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("sw 102 misal",  1, 32'h102, 3'b010, 32'h11111111, 32'h0,        1, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("sh 102 hit",    1, 32'h102, 3'b001, 32'h00001234, 32'h0,        0, 1, 3, 32'h100, 4'b1100, 32'h12340000);
    addVec("lw after sh",   0, 32'h100, 3'b010, 32'h0,        32'h1234AB21, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("lw 200 evict",  0, 32'h200, 3'b010, 32'h0,        32'h22222222, 0, 1, 3, 32'h200, 4'b0000, 32'h0);
    addVec("lw 100 refill", 0, 32'h100, 3'b010, 32'h0,        32'h1234AB21, 0, 1, 3, 32'h100, 4'b0000, 32'h0);
    addVec("lb 102 pos",    0, 32'h102, 3'b000, 32'h0,        32'h00000034, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("ld f3 110",     0, 32'h100, 3'b110, 32'h0,        32'h0,        1, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("st f3 100",     1, 32'h100, 3'b100, 32'h0,        32'h0,        1, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("sb 200 miss",   1, 32'h200, 3'b000, 32'h000000EE, 32'h0,        0, 1, 3, 32'h200, 4'b0001, 32'h000000EE);
    addVec("lw 100 kept",   0, 32'h100, 3'b010, 32'h0,        32'h1234AB21, 0, 0, 1, 32'h0,   4'b0000, 32'h0);
    addVec("lw 200 miss",   0, 32'h200, 3'b010, 32'h0,        32'h222222EE, 0, 1, 3, 32'h200, 4'b0000, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("rst resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle req_ready", {31'd0, req_ready}, 32'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd, rdata, err, lat);
      checkOutput({vecs[i].name, " rdata"}, rdata, vecs[i].expRdata);
      checkOutput({vecs[i].name, " err"}, {31'd0, err}, {31'd0, vecs[i].expErr});
      checkOutput({vecs[i].name, " latency"}, lat, vecs[i].expLat);
      checkOutput({vecs[i].name, " mem_req seen"}, {31'd0, memSeen}, {31'd0, vecs[i].expMem});
      if (vecs[i].expMem) begin
        checkOutput({vecs[i].name, " mem_addr"}, seenAddr, vecs[i].expMemAddr);
        checkOutput({vecs[i].name, " mem_we"}, {31'd0, seenWe}, {31'd0, vecs[i].we});
        if (vecs[i].we) begin
          checkOutput({vecs[i].name, " mem_wstrb"}, {28'd0, seenStrb}, {28'd0, vecs[i].expStrb});
          checkOutput({vecs[i].name, " mem_wdata"}, seenWdata, vecs[i].expMemWdata);
        end
      end
    end

    // inv together with req_valid: request refused, all lines cleared
    @(negedge clk);
    @(negedge clk);
    memSeen    = 1'b0;
    inv        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h200;
    req_funct3 = 3'b010;
    #1 checkOutput("inv req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 begin inv = 1'b0; req_valid = 1'b0; end
    @(negedge clk);
    checkOutput("inv no resp", {31'd0, resp_valid}, 32'd0);
    checkOutput("inv no mem_req", {31'd0, mem_req}, 32'd0);
    applyStimulus(1'b0, 32'h200, 3'b010, 32'h0, rdata, err, lat);
    checkOutput("post-inv lw 200 latency", lat, 32'd3);
    checkOutput("post-inv lw 200 mem_req", {31'd0, memSeen}, 32'd1);
    checkOutput("post-inv lw 200 rdata", rdata, 32'h222222EE);
    applyStimulus(1'b0, 32'h344, 3'b010, 32'h0, rdata, err, lat);
    checkOutput("post-inv lw 344 latency", lat, 32'd3);

    // Reset while a load miss waits for its ack
    memEnable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h3F8;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stall mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("stall mem_addr", mem_addr, 32'h3F8);
    checkOutput("stall resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst-in-miss mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst-in-miss resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst-in-miss req_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    memEnable = 1'b1;
    strayResp = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) strayResp++;
    end
    checkOutput("rst-in-miss stray resp", strayResp, 32'd0);
    applyStimulus(1'b0, 32'h3F8, 3'b010, 32'h0, rdata, err, lat);
    checkOutput("after rst lw 3F8 latency", lat, 32'd3);
    checkOutput("after rst lw 3F8 rdata", rdata, 32'h5A5A1234);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
